// File: rtl/calc_operand_parser_hs.sv
// Keypad-to-operand parser: ASCII key events become operand A, operand B and an opcode behind a valid/ready handshake.
// Optional feature macro CALC_NEG_OPERAND_EN enables signed operand entry with a leading '-'.
module calc_operand_parser_hs #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        key_ascii,
    input  logic                              key_pressed,
    output logic [DATA_W-1:0]                 op_a,
    output logic [DATA_W-1:0]                 op_b,
    output logic [2:0]                        op_code,
    output logic                              op_valid,
    input  logic                              op_ready,
    output logic                              err_pulse,
    output logic [1:0]                        err_code,
    output logic [1:0]                        entry_state,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [63:0]       MAX_MAG = 64'd10 ** MAX_DIGITS - 64'd1;
    localparam logic [CW-1:0]     MAX_DIG = CW'(MAX_DIGITS);
    localparam logic [DATA_W-1:0] TEN     = DATA_W'(10);

    localparam logic [7:0] KEY_BS    = 8'd8;
    localparam logic [7:0] KEY_ENTER = 8'd10;
    localparam logic [7:0] KEY_ESC   = 8'd27;
    localparam logic [7:0] KEY_MINUS = 8'h2D;
    localparam logic [7:0] KEY_STAR  = 8'h2A;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_POW = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    localparam logic [1:0] ERR_OVERFLOW  = 2'd0;
    localparam logic [1:0] ERR_MISPLACED = 2'd1;
    localparam logic [1:0] ERR_ENTER     = 2'd2;
    localparam logic [1:0] ERR_DIV_ZERO  = 2'd3;

    // Largest operand magnitude must fit below the sign bit.
    generate
        if (MAX_MAG >= (64'd1 << (DATA_W - 1))) begin : g_width_check
            $error("calc_operand_parser_hs: DATA_W too small for MAX_DIGITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [CW-1:0]       a_dig_q, a_dig_d, b_dig_q, b_dig_d;
    logic [2:0]          op_q, op_d;
    logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic                op_valid_q, op_valid_d;
    logic                err_pulse_q, err_pulse_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                key_prev_q;
    logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CW-1:0]       digit_count_q, digit_count_d;

    logic                key_event, accept;
    logic                key_is_digit, key_is_op;
    logic [2:0]          key_op;
    logic [DATA_W-1:0]   digit_ext;

    assign key_event = key_pressed & ~key_prev_q;
    assign accept    = (state_q == S_DONE) && op_valid_q && op_ready;

    // ASCII '0'..'9' carry their value in the low nibble.
    always_comb begin
        key_is_digit = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
        digit_ext    = {{(DATA_W-4){1'b0}}, key_ascii[3:0]};
        key_is_op    = 1'b1;
        key_op       = OP_ADD;
        case (key_ascii)
            8'h2B:   key_op = OP_ADD;
            8'h2D:   key_op = OP_SUB;
            8'h2A:   key_op = OP_MUL;
            8'h2F:   key_op = OP_DIV;
            8'h25:   key_op = OP_MOD;
            default: key_is_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and operand editing; ESC and a completed transfer share the clear path.
    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        a_dig_d     = a_dig_q;
        b_dig_d     = b_dig_q;
        op_d        = op_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        op_valid_d  = op_valid_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        if (accept || (key_event && key_ascii == KEY_ESC)) begin
            state_d    = S_A;
            a_mag_d    = '0;
            b_mag_d    = '0;
            a_dig_d    = '0;
            b_dig_d    = '0;
            op_d       = OP_ADD;
            a_neg_d    = 1'b0;
            b_neg_d    = 1'b0;
            op_valid_d = 1'b0;
        end else if (key_event) begin
            case (state_q)
                S_A: begin
                    if (key_is_digit) begin
                        if (a_dig_q < MAX_DIG) begin
                            a_mag_d = a_mag_q * TEN + digit_ext;
                            a_dig_d = a_dig_q + CW'(1);
                        end else begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_OVERFLOW;
                        end
                    end else if (key_ascii == KEY_BS) begin
                        if (a_dig_q != '0) begin
                            a_mag_d = a_mag_q / TEN;
                            a_dig_d = a_dig_q - CW'(1);
                        end else if (a_neg_q) begin
                            a_neg_d = 1'b0;
                        end
                    end else if (key_ascii == KEY_ENTER) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_ENTER;
                    end else if (key_is_op) begin
                        if (a_dig_q != '0) begin
                            op_d    = key_op;
                            state_d = S_B;
`ifdef CALC_NEG_OPERAND_EN
                        end else if (key_ascii == KEY_MINUS) begin
                            a_neg_d = ~a_neg_q;
`endif
                        end else begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_MISPLACED;
                        end
                    end
                end
                S_B: begin
                    if (key_is_digit) begin
                        if (b_dig_q < MAX_DIG) begin
                            b_mag_d = b_mag_q * TEN + digit_ext;
                            b_dig_d = b_dig_q + CW'(1);
                        end else begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_OVERFLOW;
                        end
                    end else if (key_ascii == KEY_BS) begin
                        if (b_dig_q != '0) begin
                            b_mag_d = b_mag_q / TEN;
                            b_dig_d = b_dig_q - CW'(1);
                        end else if (b_neg_q) begin
                            b_neg_d = 1'b0;
                        end else begin
                            op_d    = OP_ADD;
                            state_d = S_A;
                        end
                    end else if (key_ascii == KEY_ENTER) begin
                        if (b_dig_q == '0) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_ENTER;
                        end else if ((op_q == OP_DIV || op_q == OP_MOD) && b_mag_q == '0) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_DIV_ZERO;
                        end else begin
                            state_d    = S_DONE;
                            op_valid_d = 1'b1;
                        end
                    end else if (key_is_op) begin
                        if (key_ascii == KEY_STAR && op_q == OP_MUL && b_dig_q == '0) begin
                            op_d = OP_POW;
`ifdef CALC_NEG_OPERAND_EN
                        end else if (key_ascii == KEY_MINUS && b_dig_q == '0 && !b_neg_q) begin
                            b_neg_d = 1'b1;
`endif
                        end else begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_MISPLACED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        op_a_d = a_mag_d;
        op_b_d = b_mag_d;
`ifdef CALC_NEG_OPERAND_EN
        if (a_neg_d) op_a_d = -a_mag_d;
        if (b_neg_d) op_b_d = -b_mag_d;
`endif
        case (state_d)
            S_A:     digit_count_d = a_dig_d;
            S_B:     digit_count_d = b_dig_d;
            default: digit_count_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_mag_q       <= '0;
            b_mag_q       <= '0;
            a_dig_q       <= '0;
            b_dig_q       <= '0;
            op_q          <= OP_ADD;
            a_neg_q       <= 1'b0;
            b_neg_q       <= 1'b0;
            op_valid_q    <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= 2'd0;
            key_prev_q    <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            digit_count_q <= '0;
        end else begin
            a_mag_q       <= a_mag_d;
            b_mag_q       <= b_mag_d;
            a_dig_q       <= a_dig_d;
            b_dig_q       <= b_dig_d;
            op_q          <= op_d;
            a_neg_q       <= a_neg_d;
            b_neg_q       <= b_neg_d;
            op_valid_q    <= op_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
            key_prev_q    <= key_pressed;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_code     = op_q;
    assign op_valid    = op_valid_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign entry_state = state_q;
    assign digit_count = digit_count_q;

endmodule
